ov7670_frame_tx: RTL

OV7670_FRAME_TX -- requirements
Module: ov7670_frame_tx

---
 rtl/ov7670_pkg.sv | 46 ++++
 rtl/ov7670_timing_gen.sv | 101 ++++++++++
 rtl/ov7670_frame_tx.sv | 97 +++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// Shared OV7670 transmit definitions: FSM state encoding and RGB444 -> RGB565 byte split.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: tx_state_t, rgb444_t/rgb565_t pixel structs, rgb444_to_565(), cnt_width(), max_int().
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Packed so that bits [15:8] are the byte sent first and [7:0] the byte sent second.
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // MSB replication keeps full-scale 0xF mapping to full-scale 565, and lets a
    // capture side recover the 444 word by dropping the replicated LSBs.
    function automatic rgb565_t rgb444_to_565(input rgb444_t p);
        rgb565_t q;
        q.r = {p.r, p.r[3]};
        q.g = {p.g, p.g[3:2]};
        q.b = {p.b, p.b[3]};
        return q;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov7670_timing_gen.sv
// Frame timing generator: column/line counters and IDLE/VSYNC/VBACK/ACTIVE/VFRONT sequencer.
// Latency: IDLE->VSYNC one pclk after enable is seen; all outputs registered.
// Backpressure: none; free-running once started, enable only sampled in IDLE and on the last VFRONT cycle.
// Ports: pclk, reset (async active-low), enable in; state, col, vsync, busy, frame_done out.
module ov7670_timing_gen
    import ov7670_pkg::*;
#(
    parameter  int H_ACTIVE    = 320,
    parameter  int V_ACTIVE    = 240,
    parameter  int H_BLANK     = 144,
    parameter  int VSYNC_LINES = 3,
    parameter  int V_BACK      = 17,
    parameter  int V_FRONT     = 10,
    localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK,
    localparam int COL_W       = cnt_width(LINE_LEN)
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             enable,
    output tx_state_t        state,
    output logic [COL_W-1:0] col,
    output logic             vsync,
    output logic             busy,
    output logic             frame_done
);

    localparam int MAX_LINES = max_int(max_int(VSYNC_LINES, V_BACK), max_int(V_ACTIVE, V_FRONT));
    localparam int LINE_W    = cnt_width(MAX_LINES);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0] COL_PRE  = COL_W'(LINE_LEN - 2);

    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] lines_m1;
    logic              line_last;

    always_comb begin
        lines_m1 = '0;
        case (state)
            ST_VSYNC:  lines_m1 = LINE_W'(VSYNC_LINES - 1);
            ST_VBACK:  lines_m1 = LINE_W'(V_BACK - 1);
            ST_ACTIVE: lines_m1 = LINE_W'(V_ACTIVE - 1);
            ST_VFRONT: lines_m1 = LINE_W'(V_FRONT - 1);
            default:   lines_m1 = '0;
        endcase
    end

    assign line_last = (line == lines_m1);

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            col        <= '0;
            line       <= '0;
            vsync      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // Set one cycle early so the pulse lands on the last VFRONT cycle,
            // the same cycle in which enable decides restart vs. idle.
            frame_done <= (state == ST_VFRONT) && line_last && (col == COL_PRE);

            if (state == ST_IDLE) begin
                col  <= '0;
                line <= '0;
                if (enable) begin
                    state <= ST_VSYNC;
                    vsync <= 1'b1;
                    busy  <= 1'b1;
                end
            end else if (col != COL_LAST) begin
                col <= col + 1'b1;
            end else begin
                col <= '0;
                if (!line_last) begin
                    line <= line + 1'b1;
                end else begin
                    line <= '0;
                    case (state)
                        ST_VSYNC: begin
                            state <= ST_VBACK;
                            vsync <= 1'b0;
                        end
                        ST_VBACK:  state <= ST_ACTIVE;
                        ST_ACTIVE: state <= ST_VFRONT;
                        default: begin
                            if (enable) begin
                                state <= ST_VSYNC;
                                vsync <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/ov7670_frame_tx.sv
// Streams a frame from RAM as OV7670-style RGB565 bytes with vsync/href framing.
// Latency: pixel read at col 2k, its bytes on D_data at cols 2k+2 and 2k+3.
// Backpressure: none; RAM must return rd_data exactly one cycle after rd_en.
// Ports: pclk, reset (async active-low), enable, rd_data[11:0] in;
//        rd_addr[16:0], rd_en, vsync, href, D_data[7:0], frame_done, busy out.
module ov7670_frame_tx
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        enable,
    output logic [16:0] rd_addr,
    output logic        rd_en,
    input  logic [11:0] rd_data,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  D_data,
    output logic        frame_done,
    output logic        busy
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W    = cnt_width(LINE_LEN);

    localparam logic [COL_W-1:0] COL_RD_END = COL_W'(2 * H_ACTIVE);
    localparam logic [COL_W-1:0] COL_TWO    = COL_W'(2);
    localparam logic [16:0]      ADDR_LAST  = 17'(H_ACTIVE * V_ACTIVE - 1);

    tx_state_t        state;
    logic [COL_W-1:0] col;
    rgb565_t          rd_565;
    logic [7:0]       lo_byte_q;
    logic             hi_slot;
    logic             lo_slot;

    ov7670_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .pclk       (pclk),
        .reset      (reset),
        .enable     (enable),
        .state      (state),
        .col        (col),
        .vsync      (vsync),
        .busy       (busy),
        .frame_done (frame_done)
    );

    assign rd_565 = rgb444_to_565(rgb444_t'(rd_data));

    // Even cols below 2*H_ACTIVE issue reads; the following odd col sees the
    // returned word and loads the hi byte; the next even col sends the held lo byte.
    assign rd_en   = (state == ST_ACTIVE) && !col[0] && (col < COL_RD_END);
    assign hi_slot = (state == ST_ACTIVE) &&  col[0] && (col < COL_RD_END);
    assign lo_slot = (state == ST_ACTIVE) && !col[0] && (col >= COL_TWO) && (col <= COL_RD_END);

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            rd_addr   <= '0;
            href      <= 1'b0;
            D_data    <= '0;
            lo_byte_q <= '0;
        end else begin
            if (state == ST_IDLE) begin
                rd_addr <= '0;
            end else if (rd_en) begin
                // Wrap after the last pixel so back-to-back frames restart at 0.
                rd_addr <= (rd_addr == ADDR_LAST) ? 17'd0 : rd_addr + 17'd1;
            end

            if (hi_slot) begin
                href      <= 1'b1;
                D_data    <= rd_565[15:8];
                lo_byte_q <= rd_565[7:0];
            end else if (lo_slot) begin
                href   <= 1'b1;
                D_data <= lo_byte_q;
            end else begin
                href   <= 1'b0;
                D_data <= '0;
            end
        end
    end

endmodule
